// File: rtl/p_arith_pkg.sv
// Shared types and constants for the packed add/sub datapath, its arbiter
// and the multi-cycle multiplier that borrows the adder.
package p_arith_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } arb_state_e;

  // One-hot pack widths: lane size 32, 16, 8, 4 or 2 bits.
  localparam logic [4:0] PW_32 = 5'b00001;
  localparam logic [4:0] PW_16 = 5'b00010;
  localparam logic [4:0] PW_8  = 5'b00100;
  localparam logic [4:0] PW_4  = 5'b01000;
  localparam logic [4:0] PW_2  = 5'b10000;

  localparam int P_MUL_MAX_CYCLES = 33;

  typedef struct packed {
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  pw;
    logic        sub;
  } padd_op_t;

endpackage

// File: rtl/p_addsub_arb_if.sv
// Bundle of the ALU request/response, multiplier and shared-adder signals
// around p_addsub_arb; slave is the arbiter, master is everything around it.
interface p_addsub_arb_if;

  logic        add_req_valid;
  logic        add_req_ready;
  logic [31:0] add_lhs;
  logic [31:0] add_rhs;
  logic [4:0]  add_pw;
  logic        add_sub;
  logic        add_rsp_valid;
  logic [31:0] add_rsp_result;
  logic [32:0] add_rsp_carry;

  logic        mul_req;
  logic        mul_gnt;
  logic        mul_done;
  logic [31:0] mul_lhs;
  logic [31:0] mul_rhs;
  logic [4:0]  mul_pw;
  logic        mul_sub;
  logic [31:0] mul_result;
  logic [32:0] mul_carry;
  logic        mul_err;

  logic [31:0] padd_lhs;
  logic [31:0] padd_rhs;
  logic [4:0]  padd_pw;
  logic        padd_sub;
  logic [31:0] padd_result;
  logic [32:0] padd_carry;

  modport slave (
    input  add_req_valid, add_lhs, add_rhs, add_pw, add_sub,
    output add_req_ready, add_rsp_valid, add_rsp_result, add_rsp_carry,
    input  mul_req, mul_done, mul_lhs, mul_rhs, mul_pw, mul_sub,
    output mul_gnt, mul_result, mul_carry, mul_err,
    output padd_lhs, padd_rhs, padd_pw, padd_sub,
    input  padd_result, padd_carry
  );

  modport master (
    output add_req_valid, add_lhs, add_rhs, add_pw, add_sub,
    input  add_req_ready, add_rsp_valid, add_rsp_result, add_rsp_carry,
    output mul_req, mul_done, mul_lhs, mul_rhs, mul_pw, mul_sub,
    input  mul_gnt, mul_result, mul_carry, mul_err,
    input  padd_lhs, padd_rhs, padd_pw, padd_sub,
    output padd_result, padd_carry
  );

endinterface

// File: rtl/p_addsub_arb.sv
// Shares one external p_addsub between a single-cycle ALU port and p_mul_core.
// Define P_ADDSUB_ARB_STATS_EN to add the saturating add_stall_cnt output.
module p_addsub_arb
  import p_arith_pkg::*;
#(
  parameter int MUL_TIMEOUT = 40,
  parameter int STAT_W      = 16
) (
  input  logic          clock,
  input  logic          resetn,
  p_addsub_arb_if.slave bus
`ifdef P_ADDSUB_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] add_stall_cnt
`endif
);

  localparam int              TMO_W    = $clog2(MUL_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MUL_TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             prio_q, prio_d;
  logic             mul_block_q, mul_block_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [32:0]      rsp_carry_q, rsp_carry_d;
  logic             mul_err_q, mul_err_d;

  logic     mul_req_ok;
  logic     gnt_add;
  logic     gnt_mul;
  padd_op_t alu_op;
  padd_op_t mul_op;
  padd_op_t padd_op;

  assign alu_op = '{lhs: bus.add_lhs, rhs: bus.add_rhs, pw: bus.add_pw, sub: bus.add_sub};
  assign mul_op = '{lhs: bus.mul_lhs, rhs: bus.mul_rhs, pw: bus.mul_pw, sub: bus.mul_sub};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      mul_block_q  <= 1'b0;
      tmo_cnt_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= '0;
      mul_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      mul_block_q  <= mul_block_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      mul_err_q    <= mul_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    mul_block_d  = mul_block_q;
    tmo_cnt_d    = tmo_cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    mul_err_d    = 1'b0;

    // A timed-out requester must withdraw for one cycle before it can win again.
    if (!bus.mul_req) begin
      mul_block_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (gnt_add) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = bus.padd_result;
          rsp_carry_d  = bus.padd_carry;
          if (mul_req_ok) begin
            prio_d = 1'b1;
          end
        end else if (gnt_mul) begin
          if (bus.mul_done) begin
            prio_d = 1'b0;
          end else begin
            state_d   = MUL_BUSY;
            tmo_cnt_d = TMO_W'(1);
          end
        end
      end
      MUL_BUSY: begin
        if (!bus.mul_req || bus.mul_done) begin
          state_d   = IDLE;
          prio_d    = 1'b0;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = IDLE;
          prio_d      = 1'b0;
          tmo_cnt_d   = '0;
          mul_err_d   = 1'b1;
          mul_block_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grants are gated by resetn so the multiplier sees valid drop during reset.
  always_comb begin
    mul_req_ok = bus.mul_req && !mul_block_q;
    gnt_add    = 1'b0;
    gnt_mul    = 1'b0;
    if (resetn) begin
      unique case (state_q)
        IDLE: begin
          gnt_add = bus.add_req_valid && (!mul_req_ok || !prio_q);
          gnt_mul = mul_req_ok && !gnt_add;
        end
        MUL_BUSY: begin
          gnt_mul = bus.mul_req;
        end
        default: begin
          gnt_mul = 1'b0;
        end
      endcase
    end

    padd_op = '0;
    if (gnt_add) begin
      padd_op = alu_op;
    end else if (gnt_mul) begin
      padd_op = mul_op;
    end
  end

  assign bus.add_req_ready  = gnt_add;
  assign bus.add_rsp_valid  = rsp_valid_q;
  assign bus.add_rsp_result = rsp_result_q;
  assign bus.add_rsp_carry  = rsp_carry_q;

  assign bus.mul_gnt    = gnt_mul;
  assign bus.mul_result = bus.padd_result;
  assign bus.mul_carry  = bus.padd_carry;
  assign bus.mul_err    = mul_err_q;

  assign bus.padd_lhs = padd_op.lhs;
  assign bus.padd_rhs = padd_op.rhs;
  assign bus.padd_pw  = padd_op.pw;
  assign bus.padd_sub = padd_op.sub;

`ifdef P_ADDSUB_ARB_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.add_req_valid && !gnt_add && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  assign add_stall_cnt = stall_cnt_q;
`else
  // STAT_W only sizes the stall counter, which is not built here.
  logic [STAT_W-1:0] stats_unused;
  assign stats_unused = '0;
`endif

endmodule

// File: doc/p_addsub_arb.md
Name: p_addsub_arb

Overview:
- Arbiter and sequencer that shares one p_addsub instance between a single-cycle packed add/sub requester (ALU port) and a multi-cycle p_mul_core (MUL port).
- The multiplier needs the adder on every cycle of its operation, and its step counter clears whenever its valid input drops, so a MUL grant is locked until the multiply completes.
- Sits between the instruction issue logic, p_mul_core's padd_* interface and the shared p_addsub.

Parameters:
- MUL_TIMEOUT, 40, maximum cycles a MUL grant may be held before forced release (≥ 34; the longest multiply is 33 cycles).
- STAT_W, 16, width of the optional stall counter.

Ports:
- clock  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- add_req_valid  in  1  ALU add/sub request
- add_req_ready  out  1  request accepted this cycle
- add_lhs  in  32  ALU left operand
- add_rhs  in  32  ALU right operand
- add_pw  in  5  ALU one-hot pack width
- add_sub  in  1  ALU subtract select
- add_rsp_valid  out  1  one-cycle pulse, response registers updated
- add_rsp_result  out  32  registered sum
- add_rsp_carry  out  33  registered carries
- mul_req  in  1  issue wants a multiply
- mul_gnt  out  1  drives p_mul_core valid
- mul_done  in  1  p_mul_core ready
- mul_lhs  in  32  p_mul_core padd_lhs
- mul_rhs  in  32  p_mul_core padd_rhs
- mul_pw  in  5  p_mul_core padd_pw
- mul_sub  in  1  p_mul_core padd_sub
- mul_result  out  32  to p_mul_core padd_result
- mul_carry  out  33  to p_mul_core padd_carry
- mul_err  out  1  one-cycle pulse on timeout
- padd_lhs  out  32  shared adder left input
- padd_rhs  out  32  shared adder right input
- padd_pw  out  5  shared adder pack width
- padd_sub  out  1  shared adder subtract select
- padd_result  in  32  shared adder result
- padd_carry  in  33  shared adder carries

Behaviour:
- States: IDLE, MUL_BUSY.
- Registers: prio (0 = ALU favoured, reset 0), tmo_cnt, mul_block, response registers.
- Reset values: all outputs 0; state IDLE; prio 0; mul_block 0; tmo_cnt 0.
- IDLE arbitration (combinational, same cycle):
  - gnt_add = add_req_valid && (!mul_req_ok || prio==0).
  - gnt_mul = mul_req_ok && !gnt_add.
  - mul_req_ok = mul_req && !mul_block.
- add_req_ready = gnt_add.
- On gnt_add: add_rsp_* are loaded from padd_*, and add_rsp_valid pulses the next cycle. Set prio=1 if mul_req_ok, else keep prio.
- Response registers hold their value between grants.
- On gnt_mul:
  - mul_gnt=1.
  - If mul_done in the same cycle, stay IDLE and set prio=0.
  - Otherwise go to MUL_BUSY with tmo_cnt=1.
- MUL_BUSY:
  - mul_gnt = mul_req; adder muxed to the MUL port; add_req_ready=0; tmo_cnt increments each cycle.
  - mul_done → IDLE, prio=0.
  - mul_req low (abort) → mul_gnt=0 in the same cycle, then IDLE, prio=0.
  - tmo_cnt == MUL_TIMEOUT−1 without done → IDLE, mul_gnt=0 from the next cycle.
    - Pulse mul_err the next cycle.
    - Set mul_block=1 and prio=0.
- mul_block clears on any cycle with mul_req=0.
- Shared adder mux:
  - ALU operands when gnt_add.
  - MUL operands when mul_gnt.
  - Otherwise all zero.
- mul_result and mul_carry always mirror padd_result and padd_carry.
- add_pw and mul_pw are forwarded unmodified; a non-one-hot value gives an undefined result but does not disturb the arbitration.
- Reset mid-MUL: IDLE on the next edge; mul_gnt=0 (clears p_mul_core); no mul_err.
- ALU latency: 1 cycle from accept to add_rsp_valid. Back-to-back ALU accepts are legal while the MUL port is idle.

Optional Feature:
- Macro P_ADDSUB_ARB_STATS_EN.
- Defined:
  - Adds output port add_stall_cnt [STAT_W].
  - Counts cycles with add_req_valid && !add_req_ready.
  - Saturates at all-ones; reset 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package p_arith_pkg:
  - State enum, with IDLE=0 and MUL_BUSY=1.
  - One-hot pack-width constants PW_32=5'b00001, PW_16, PW_8, PW_4, PW_2=5'b10000.
  - P_MUL_MAX_CYCLES=33.
- Single module; no sub-module.
- The p_addsub instance stays outside this module so that a top level can share it further.

Test Plan:
- ALU only: lhs 0x5, rhs 0x3, PW_32, sub=0 → add_req_ready=1 in the same cycle; add_rsp_valid the next cycle with result 0x8, carry 0.
- MUL only, PW_32, crs1=3, crs2=5:
  - mul_gnt high for 33 cycles, then mul_done.
  - p_mul_core result 15.
  - An ALU request raised at cycle 2 is accepted the cycle after mul_done.
- Simultaneous after reset:
  - prio=0, so the ALU is accepted at cycle 0 and mul_gnt rises at cycle 1.
  - The next contention after the MUL finishes goes to the ALU.
- Abort: mul_req dropped at MUL cycle 10 → mul_gnt=0 in the same cycle; a pending ALU request is accepted the next cycle; no mul_err.
- Timeout:
  - mul_done tied 0 → mul_gnt drops after 40 cycles and mul_err pulses once.
  - With mul_req still high, no re-grant occurs until mul_req has been low for one cycle.
- Reset at MUL cycle 5 → mul_gnt=0, add_rsp_valid=0, all padd_* = 0 after the edge; a normal MUL completes afterwards.
